// File: rtl/controlador_led.sv
// controlador_led: turns one-cycle event pulses into active-low LED blink
// sequences. Each request produces BLINKS on/off cycles; requests arriving
// while a sequence runs are held in a saturating pending counter and replayed
// back-to-back with no idle gap.
//
// Optional build macro: LED_DROP_FLAG_EN adds a registered one-cycle
// `dropped` output that flags requests discarded because the pending counter
// was already full.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no sequence running, LED dark, busy low
// ON    | LED lit for ON_CYCLES periods of the current blink
// OFF   | LED dark for OFF_CYCLES periods; after the last blink either
//       | start the next buffered request or return to IDLE
module controlador_led #(
    parameter int ON_CYCLES  = 16,
    parameter int OFF_CYCLES = 16,
    parameter int BLINKS     = 3,
    parameter int QUEUE_MAX  = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           p_in,
    output logic                           led_out,
    output logic                           busy,
`ifdef LED_DROP_FLAG_EN
    output logic                           dropped,
`endif
    output logic [$clog2(QUEUE_MAX+1)-1:0] pending
);

    localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int BW     = $clog2(BLINKS + 1);
    localparam int QW     = $clog2(QUEUE_MAX + 1);

    // Phase counter runs down to zero; the terminal count ends the phase.
    localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BLINKS - 1);
    localparam logic [QW-1:0] Q_MAX    = QW'(QUEUE_MAX);
    localparam logic [QW-1:0] Q_ONE    = QW'(1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   phase_cnt, phase_next;
    logic [BW-1:0]   blink_cnt, blink_next;
    logic [QW-1:0]   pending_next;
    logic            led_next, busy_next;
    logic            last_off;

    assign last_off = (state == ST_OFF) && (phase_cnt == '0) && (blink_cnt == B_LAST);

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            blink_cnt <= '0;
            pending   <= '0;
            led_out   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            blink_cnt <= blink_next;
            pending   <= pending_next;
            led_out   <= led_next;
            busy      <= busy_next;
        end
    end

    // Next state, phase/blink counters and pending-request bookkeeping.
    always_comb begin
        state_next   = state;
        phase_next   = phase_cnt;
        blink_next   = blink_cnt;
        pending_next = pending;

        case (state)
            ST_IDLE: begin
                if (p_in) begin
                    state_next = ST_ON;
                    phase_next = ON_LAST;
                    blink_next = '0;
                end
            end
            ST_ON: begin
                if (phase_cnt == '0) begin
                    state_next = ST_OFF;
                    phase_next = OFF_LAST;
                end else begin
                    phase_next = phase_cnt - P_ONE;
                end
            end
            ST_OFF: begin
                if (phase_cnt != '0) begin
                    phase_next = phase_cnt - P_ONE;
                end else if (blink_cnt != B_LAST) begin
                    state_next = ST_ON;
                    phase_next = ON_LAST;
                    blink_next = blink_cnt + B_ONE;
                end else if ((pending != '0) || p_in) begin
                    // A request arriving on this very edge is served at once,
                    // exactly as if it had been queued earlier.
                    state_next = ST_ON;
                    phase_next = ON_LAST;
                    blink_next = '0;
                end else begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                    blink_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
                blink_next = '0;
            end
        endcase

        // While busy, a new request adds one; a dequeue at the end of the last
        // OFF phase removes one. Both at once leave the count unchanged, which
        // also keeps a full queue full while still accepting the new request.
        if (state != ST_IDLE) begin
            if (last_off) begin
                if ((pending != '0) && !p_in) begin
                    pending_next = pending - Q_ONE;
                end
            end else if (p_in && (pending != Q_MAX)) begin
                pending_next = pending + Q_ONE;
            end
        end
    end

    // Output decode from the next state so the pins come straight from flops.
    always_comb begin
        led_next  = (state_next != ST_ON);
        busy_next = (state_next != ST_IDLE);
    end

`ifdef LED_DROP_FLAG_EN
    logic drop_next;

    // A request is lost only when the queue is full and nothing leaves it.
    always_comb begin
        drop_next = (state != ST_IDLE) && p_in && (pending == Q_MAX) && !last_off;
    end

    // One-cycle overflow indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else begin
            dropped <= drop_next;
        end
    end
`endif

endmodule
